rv_mem_mp: RTL

//  Multi-port, pipelined valid/ready memory model; generalised successor of the single-port rv_mem/rv_rom sim memories.

---
 rtl/rv_mem_mp.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/rv_mem_mp.sv
// Multi-port valid/ready memory model: round-robin arbitrated shared word array with per-port response FIFOs.
// Optional write-misalignment check enabled by defining RV_MEM_MP_MISALIGN_CHK_EN.
module rv_mem_mp #(
    parameter int          NPORTS      = 2,
    parameter int          BYTES       = 4096,
    parameter int          DEPTH       = 4,
    parameter int          LATENCY     = 1,
    parameter int          RANDOM_WAIT = 0,
    parameter int          WAIT_MAX    = 7,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NPORTS-1:0]      req_valid,
    output logic [NPORTS-1:0]      req_ready,
    input  logic [32*NPORTS-1:0]   req_addr,
    input  logic [32*NPORTS-1:0]   req_wdata,
    input  logic [4*NPORTS-1:0]    req_wstrb,
    output logic [NPORTS-1:0]      resp_valid,
    input  logic [NPORTS-1:0]      resp_ready,
    output logic [32*NPORTS-1:0]   resp_rdata
);

    localparam int          WORDS     = BYTES / 4;
    localparam int          IW        = $clog2(WORDS);
    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW        = $clog2(DEPTH) + 1;
    localparam int          PW        = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int          DW        = $clog2(LATENCY + WAIT_MAX + 1);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    logic [31:0]       mem [WORDS];
    logic [PW-1:0]     rr_ptr_reg;
    logic [NPORTS-1:0] full;
    logic [NPORTS-1:0] grant;
    logic              accept;
    logic [PW-1:0]     gidx;
    logic [PW-1:0]     scan_idx;

    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_wstrb;
    logic [IW-1:0]     acc_idx;
    logic              acc_bad;
    logic              acc_wr_en;
    logic [31:0]       push_data;
    logic              unused_addr_bits;

    // First requesting, non-full port at or after rr_ptr wins; nothing is granted while in reset.
    always_comb begin
        grant    = '0;
        gidx     = '0;
        accept   = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NPORTS; k++) begin
            scan_idx = PW'((int'(rr_ptr_reg) + k) % NPORTS);
            if (!accept && rst_n && req_valid[scan_idx] && !full[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                gidx            = scan_idx;
                accept          = 1'b1;
            end
        end
    end

    assign req_ready = grant;

    always_comb begin
        acc_addr  = req_addr[32*gidx +: 32];
        acc_wdata = req_wdata[32*gidx +: 32];
        acc_wstrb = req_wstrb[4*gidx +: 4];
        acc_idx   = acc_addr[IW+1:2];
`ifdef RV_MEM_MP_MISALIGN_CHK_EN
        acc_bad   = |(acc_wstrb & ((4'b0001 << acc_addr[1:0]) - 4'b0001));
`else
        acc_bad   = 1'b0;
`endif
        acc_wr_en = accept && (|acc_wstrb) && !acc_bad;
        if (acc_bad)
            push_data = 32'hBADC0DE5;
        else if (|acc_wstrb)
            push_data = 32'h0;
        else
            push_data = mem[acc_idx];
    end

    assign unused_addr_bits = ^{acc_addr[31:IW+2], acc_addr[1:0]};

    // Reads capture the pre-write contents, so this edge's write is invisible to them.
    always_ff @(posedge clk) begin
        if (acc_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_wstrb[b])
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

`ifdef RV_MEM_MP_MISALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (accept && acc_bad)
            $error("rv_mem_mp: misaligned write suppressed port=%0d addr=%h wstrb=%b", gidx, acc_addr, acc_wstrb);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr_reg <= '0;
        else if (accept)
            rr_ptr_reg <= (gidx == PW'(NPORTS - 1)) ? '0 : gidx + PW'(1);
    end

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
            localparam logic [15:0] SEED_X = SEED ^ 16'(gi);
            localparam logic [15:0] SEED_P = (SEED_X == 16'h0) ? 16'h0001 : SEED_X;

            logic [31:0]   data_q [DEPTH];
            logic [DW-1:0] dly_q  [DEPTH];
            logic [AW-1:0] wr_ptr_reg;
            logic [AW-1:0] rd_ptr_reg;
            logic [CW-1:0] count_reg;
            logic [DW-1:0] timer_reg;
            logic [15:0]   lfsr_reg;
            logic [31:0]   last_reg;
            logic [AW-1:0] wr_ptr_next;
            logic [AW-1:0] rd_ptr_next;
            logic [15:0]   lfsr_next;
            logic [DW-1:0] push_d;
            logic          push;
            logic          pop;
            logic          empty;
            logic          head_valid;

            assign empty       = (count_reg == '0);
            assign full[gi]    = (count_reg == CW'(DEPTH));
            assign push        = grant[gi];
            assign head_valid  = !empty && (timer_reg == '0);
            assign pop         = head_valid && resp_ready[gi];
            assign wr_ptr_next = (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
            assign rd_ptr_next = (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + AW'(1);
            assign lfsr_next   = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ LFSR_TAPS) : (lfsr_reg >> 1);
            assign push_d      = (RANDOM_WAIT != 0)
                               ? DW'(LATENCY - 1) + DW'(lfsr_reg % 16'(WAIT_MAX + 1))
                               : DW'(LATENCY - 1);

            assign resp_valid[gi]         = head_valid;
            assign resp_rdata[32*gi +: 32] = head_valid ? data_q[rd_ptr_reg] : last_reg;

            always_ff @(posedge clk) begin
                if (push) begin
                    data_q[wr_ptr_reg] <= push_data;
                    dly_q[wr_ptr_reg]  <= push_d;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                    timer_reg  <= '0;
                    lfsr_reg   <= SEED_P;
                    last_reg   <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_next;
                        lfsr_reg   <= lfsr_next;
                    end
                    if (pop) begin
                        rd_ptr_reg <= rd_ptr_next;
                        last_reg   <= data_q[rd_ptr_reg];
                    end
                    if (push && !pop)
                        count_reg <= count_reg + CW'(1);
                    else if (!push && pop)
                        count_reg <= count_reg - CW'(1);
                    // Only the head's delay runs; a new head loads its own delay.
                    if (pop) begin
                        if (count_reg > CW'(1))
                            timer_reg <= dly_q[rd_ptr_next];
                        else if (push)
                            timer_reg <= push_d;
                    end else if (empty && push) begin
                        timer_reg <= push_d;
                    end else if (timer_reg != '0) begin
                        timer_reg <= timer_reg - DW'(1);
                    end
                end
            end
        end
    endgenerate

endmodule
